// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_t;

  // Counter width able to hold values 0..n-1 (at least 1 bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level (1).
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb sync_d = {sync_q[0], d};

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: oversampled FSM, optional parity, 1/2 stop bits,
// single-entry ready/valid output buffer with parity/framing/overrun flags.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned WORDSIZE    = 8,
  parameter int unsigned OVERSAMPLE  = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                sclk,
  input  logic                reset,
  input  logic                serial_in,
  input  logic                rx_ready,
  output logic [WORDSIZE-1:0] rx_data,
  output logic                rx_valid,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overrun_err,
  output logic                busy
);

  localparam int unsigned SW = cnt_w(OVERSAMPLE);
  localparam int unsigned BW = cnt_w(WORDSIZE + 1);
  localparam logic [SW-1:0] HALF_M1   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_M1   = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(WORDSIZE - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam parity_t       PMODE     = parity_t'(2'(PARITY_MODE));
  localparam bit            PAR_EN    = (PMODE != PAR_NONE);
  localparam bit            PAR_ODD_L = (PMODE == PAR_ODD);

  logic rx_s;

  rx_state_t             state_q, state_d;
  logic [SW-1:0]         sample_cnt_q, sample_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [WORDSIZE-1:0]   sh_q, sh_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic [WORDSIZE-1:0]   rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  busy_q, busy_d;
  logic                  done;
  logic                  ferr_final;
  logic                  bit_tick;

  uart_rx_sync u_sync (
    .clk   (sclk),
    .rst_n (reset),
    .d     (serial_in),
    .q     (rx_s)
  );

  // Next-state, datapath and output-buffer logic.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    sh_d         = sh_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
    done         = 1'b0;
    ferr_final   = ferr_q;
    bit_tick     = (sample_cnt_q == FULL_M1);

    unique case (state_q)
      IDLE: begin
        sample_cnt_d = '0;
        bit_cnt_d    = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (sample_cnt_q == HALF_M1) begin
          sample_cnt_d = '0;
          bit_cnt_d    = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end else begin
          sample_cnt_d = sample_cnt_q + SW'(1);
        end
      end
      DATA: begin
        sample_cnt_d = sample_cnt_q + SW'(1);
        if (bit_tick) begin
          sh_d = {rx_s, sh_q[WORDSIZE-1:1]};
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = PAR_EN ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      PARITY: begin
        sample_cnt_d = sample_cnt_q + SW'(1);
        if (bit_tick) begin
          perr_d  = (^{sh_q, rx_s}) ^ PAR_ODD_L;
          state_d = STOP;
        end
      end
      STOP: begin
        sample_cnt_d = sample_cnt_q + SW'(1);
        if (bit_tick) begin
          ferr_final = ferr_q | ~rx_s;
          ferr_d     = ferr_final;
          if (bit_cnt_q == LAST_STOP) begin
            done      = 1'b1;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Consumer drain; a same-cycle new word below overrides it.
    if (rx_valid_q && rx_ready) begin
      rx_valid_d   = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
    end

    if (done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = sh_q;
        parity_err_d = perr_q;
        frame_err_d  = ferr_final;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sclk) begin
    if (!reset) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      sh_q         <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      sh_q         <= sh_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: default, even-parity and two-stop-bit instances.
module tb_uart_rx_cfg;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  logic reset;
  logic rx_ready;
  logic tx;
  int   sel;
  logic s0, s1, s2;

  assign s0 = (sel == 0) ? tx : 1'b1;
  assign s1 = (sel == 1) ? tx : 1'b1;
  assign s2 = (sel == 2) ? tx : 1'b1;

  logic [7:0] d0, d1, d2;
  logic v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2, b0, b1, b2;

  uart_rx_cfg dut (
    .sclk(sclk), .reset(reset), .serial_in(s0), .rx_ready(rx_ready),
    .rx_data(d0), .rx_valid(v0), .parity_err(pe0), .frame_err(fe0),
    .overrun_err(ov0), .busy(b0)
  );

  uart_rx_cfg #(.PARITY_MODE(1)) dut_p (
    .sclk(sclk), .reset(reset), .serial_in(s1), .rx_ready(rx_ready),
    .rx_data(d1), .rx_valid(v1), .parity_err(pe1), .frame_err(fe1),
    .overrun_err(ov1), .busy(b1)
  );

  uart_rx_cfg #(.STOP_BITS(2)) dut_s (
    .sclk(sclk), .reset(reset), .serial_in(s2), .rx_ready(rx_ready),
    .rx_data(d2), .rx_valid(v2), .parity_err(pe2), .frame_err(fe2),
    .overrun_err(ov2), .busy(b2)
  );

  logic [7:0] m_data;
  logic m_valid, m_pe, m_fe, m_ovr, m_busy;
  assign m_data  = (sel == 0) ? d0  : (sel == 1) ? d1  : d2;
  assign m_valid = (sel == 0) ? v0  : (sel == 1) ? v1  : v2;
  assign m_pe    = (sel == 0) ? pe0 : (sel == 1) ? pe1 : pe2;
  assign m_fe    = (sel == 0) ? fe0 : (sel == 1) ? fe1 : fe2;
  assign m_ovr   = (sel == 0) ? ov0 : (sel == 1) ? ov1 : ov2;
  assign m_busy  = (sel == 0) ? b0  : (sel == 1) ? b1  : b2;

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  // Output monitor on the falling edge.
  int   vcnt = 0;
  int   ocnt = 0;
  int   first_cyc = 0;
  int   start_cyc = 0;
  logic prev_v = 1'b0;
  logic [7:0] cap_data = '0;
  logic cap_pe = 1'b0;
  logic cap_fe = 1'b0;

  always @(negedge sclk) begin
    if (m_valid && !prev_v) first_cyc = cyc;
    if (m_valid) begin
      vcnt     = vcnt + 1;
      cap_data = m_data;
      cap_pe   = m_pe;
      cap_fe   = m_fe;
    end
    if (m_ovr) ocnt = ocnt + 1;
    prev_v = m_valid;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    tx = b;
    wait_cyc(8);
  endtask

  // Called at posedge+1; start bit, LSB-first data, optional parity, stop bits.
  task automatic send_frame(input logic [7:0] data, input bit par_en, input logic par_bit,
                            input logic stop0, input logic stop1, input int nstop);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    if (par_en) send_bit(par_bit);
    send_bit(stop0);
    if (nstop == 2) send_bit(stop1);
    tx = 1'b1;
  endtask

  initial begin
    reset = 1'b0; rx_ready = 1'b0; tx = 1'b1; sel = 0;
    wait_cyc(3);
    check("rst_data",  32'(m_data),  32'h0);
    check("rst_valid", 32'(m_valid), 32'h0);
    check("rst_perr",  32'(m_pe),    32'h0);
    check("rst_ferr",  32'(m_fe),    32'h0);
    check("rst_ovr",   32'(m_ovr),   32'h0);
    check("rst_busy",  32'(m_busy),  32'h0);
    reset = 1'b1;
    wait_cyc(5);

    // Plain frame with consumer always ready.
    rx_ready = 1'b1; vcnt = 0; ocnt = 0;
    send_frame(8'hA5, 0, 1'b0, 1'b1, 1'b1, 1);
    wait_cyc(10);
    check("t1_data",    32'(cap_data), 32'hA5);
    check("t1_perr",    32'(cap_pe),   32'h0);
    check("t1_ferr",    32'(cap_fe),   32'h0);
    check("t1_vcycles", 32'(vcnt),     32'd1);
    check("t1_latency", 32'(first_cyc - start_cyc), 32'd79);
    check("t1_ovr",     32'(ocnt),     32'h0);

    // Two-cycle start glitch is rejected.
    vcnt = 0;
    tx = 1'b0;
    wait_cyc(2);
    tx = 1'b1;
    wait_cyc(3);
    check("t2_busy_hi", 32'(m_busy), 32'h1);
    wait_cyc(12);
    check("t2_busy_lo", 32'(m_busy), 32'h0);
    check("t2_novalid", 32'(vcnt),   32'h0);

    // Even parity: bad then good parity bit.
    sel = 1; vcnt = 0;
    wait_cyc(2);
    send_frame(8'h3C, 1, 1'b1, 1'b1, 1'b1, 1);
    wait_cyc(10);
    check("t3a_data",    32'(cap_data), 32'h3C);
    check("t3a_perr",    32'(cap_pe),   32'h1);
    check("t3a_latency", 32'(first_cyc - start_cyc), 32'd87);
    send_frame(8'h3C, 1, 1'b0, 1'b1, 1'b1, 1);
    wait_cyc(10);
    check("t3b_data",  32'(cap_data), 32'h3C);
    check("t3b_perr",  32'(cap_pe),   32'h0);
    check("t3b_count", 32'(vcnt),     32'd2);

    // Framing errors: low stop bit, then low second stop bit.
    sel = 0;
    wait_cyc(2);
    send_frame(8'h81, 0, 1'b0, 1'b0, 1'b1, 1);
    wait_cyc(20);
    check("t4a_data", 32'(cap_data), 32'h81);
    check("t4a_ferr", 32'(cap_fe),   32'h1);
    check("t4a_busy", 32'(m_busy),   32'h0);
    sel = 2;
    wait_cyc(2);
    send_frame(8'h81, 0, 1'b0, 1'b1, 1'b0, 2);
    wait_cyc(20);
    check("t4b_data",    32'(cap_data), 32'h81);
    check("t4b_ferr",    32'(cap_fe),   32'h1);
    check("t4b_latency", 32'(first_cyc - start_cyc), 32'd87);
    send_frame(8'h5A, 0, 1'b0, 1'b1, 1'b1, 2);
    wait_cyc(10);
    check("t4c_data", 32'(cap_data), 32'h5A);
    check("t4c_ferr", 32'(cap_fe),   32'h0);

    // Overrun: consumer stalled across two back-to-back frames.
    sel = 0; rx_ready = 1'b0; ocnt = 0;
    wait_cyc(2);
    send_frame(8'h11, 0, 1'b0, 1'b1, 1'b1, 1);
    send_frame(8'h22, 0, 1'b0, 1'b1, 1'b1, 1);
    wait_cyc(10);
    check("t5a_data",  32'(m_data),  32'h11);
    check("t5a_valid", 32'(m_valid), 32'h1);
    check("t5a_ovr",   32'(ocnt),    32'd1);

    // Same-cycle drain and reload: no overrun.
    fork
      send_frame(8'h22, 0, 1'b0, 1'b1, 1'b1, 1);
      begin
        repeat (78) @(posedge sclk);
        #1 rx_ready = 1'b1;
        @(posedge sclk);
        #1 rx_ready = 1'b0;
      end
    join
    wait_cyc(5);
    check("t5b_data",  32'(m_data),  32'h22);
    check("t5b_valid", 32'(m_valid), 32'h1);
    check("t5b_ovr",   32'(ocnt),    32'd1);

    // Reset mid-DATA; all-ones data keeps the line high after the reset.
    fork
      send_frame(8'hFF, 0, 1'b0, 1'b1, 1'b1, 1);
      begin
        wait_cyc(30);
        check("t6_busy_pre", 32'(m_busy), 32'h1);
        reset = 1'b0;
        @(posedge sclk);
        #1;
        check("t6_rst_data",  32'(m_data),  32'h0);
        check("t6_rst_valid", 32'(m_valid), 32'h0);
        check("t6_rst_busy",  32'(m_busy),  32'h0);
        check("t6_rst_ferr",  32'(m_fe),    32'h0);
        reset = 1'b1;
      end
    join
    wait_cyc(5);
    rx_ready = 1'b1; vcnt = 0; ocnt = 0;
    send_frame(8'h5A, 0, 1'b0, 1'b1, 1'b1, 1);
    wait_cyc(10);
    check("t6_data",    32'(cap_data), 32'h5A);
    check("t6_perr",    32'(cap_pe),   32'h0);
    check("t6_ferr",    32'(cap_fe),   32'h0);
    check("t6_vcycles", 32'(vcnt),     32'd1);
    check("t6_latency", 32'(first_cyc - start_cyc), 32'd79);
    check("t6_ovr",     32'(ocnt),     32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
